// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the mode-0 SPI master
// and the SPI_Slave-compatible link side.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_RELEASE
  } spi_state_e;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  localparam int unsigned SPI_MODE      = 0;
  localparam int unsigned BITS_PER_BYTE = 8;

  function automatic int hb_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-bit counter producing SCLK and the
// rise/fall ticks that the master FSM acts on.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold_low,
  output logic half,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int CW = hb_cnt_w(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt;

  // Ticks flag the edge that ends the current half period.
  assign half = en && (cnt == LAST);
  assign rise = half && !sclk && !hold_low;
  assign fall = half && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else if (half) begin
      cnt  <= '0;
      sclk <= rise;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide mode-0 SPI master with CS hold for
// back-to-back bytes and a minimum CS inactive gap.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_CS_Hold,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  output logic       o_SPI_MOSI,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_CS_n
);

  localparam int RW = hb_cnt_w(CS_INACTIVE_CLKS);
  localparam logic [RW-1:0] REL_LAST = RW'(CS_INACTIVE_CLKS - 1);

  spi_state_e state, state_d;

  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          rdy_q, rdy_d;
  logic          rxdv_q, rxdv_d;
  logic [7:0]    rxb_q, rxb_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [RW-1:0] rel_cnt, rel_cnt_d;

  logic accept;
  logic cg_en, cg_low, half, rise, fall;

  assign accept = i_TX_DV && rdy_q;
  assign cg_en  = (state == ST_SETUP) || (state == ST_XFER);
  assign cg_low = (state == ST_SETUP);

  spi_clk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_clk_gen (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .en      (cg_en),
    .hold_low(cg_low),
    .half    (half),
    .rise    (rise),
    .fall    (fall),
    .sclk    (o_SPI_Clk)
  );

  always_comb begin
    state_d   = state;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    rdy_d     = rdy_q;
    rxdv_d    = 1'b0;
    rxb_d     = rxb_q;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    bit_cnt_d = bit_cnt;
    rel_cnt_d = rel_cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          cs_n_d    = 1'b0;
          mosi_d    = i_TX_Byte[7];
          tx_sh_d   = i_TX_Byte;
          rdy_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_SETUP: begin
        if (half) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (rise) rx_sh_d = {rx_sh[6:0], i_SPI_MISO};
        if (fall) begin
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rxdv_d = 1'b1;
            rxb_d  = rx_sh;
            mosi_d = 1'b0;
            if (i_CS_Hold) begin
              state_d = ST_HOLD;
              rdy_d   = 1'b1;
            end else begin
              state_d   = ST_RELEASE;
              cs_n_d    = 1'b1;
              rel_cnt_d = '0;
            end
          end else begin
            tx_sh_d = {tx_sh[6:0], 1'b0};
            mosi_d  = tx_sh[6];
          end
        end
      end
      ST_HOLD: begin
        // A new byte wins over a simultaneous drop of CS hold.
        if (accept) begin
          state_d   = ST_XFER;
          mosi_d    = i_TX_Byte[7];
          tx_sh_d   = i_TX_Byte;
          rdy_d     = 1'b0;
          bit_cnt_d = '0;
        end else if (!i_CS_Hold) begin
          state_d   = ST_RELEASE;
          cs_n_d    = 1'b1;
          rdy_d     = 1'b0;
          rel_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt == REL_LAST) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
        end else begin
          rel_cnt_d = rel_cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= ST_IDLE;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b1;
      rxdv_q  <= 1'b0;
      rxb_q   <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      rxdv_q  <= rxdv_d;
      rxb_q   <= rxb_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      bit_cnt <= bit_cnt_d;
      rel_cnt <= rel_cnt_d;
    end
  end

  assign o_SPI_CS_n = cs_n_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_TX_Ready = rdy_q;
  assign o_RX_DV    = rxdv_q;
  assign o_RX_Byte  = rxb_q;

endmodule
